// File: rtl/fm_sb_init_seq.sv
// Spy-memory init sequencer: freeze selected buffers, settle, zero-fill each via shared write port, pulse ptr reset.
// Latency: busy rises on the start edge; first write SETTLE_CYC cycles later; done in the last busy cycle.
// Backpressure: wr_ready low holds the current write (sel/addr stable) indefinitely; abort returns to IDLE next cycle.
module fm_sb_init_seq #(
    parameter  int SB_N       = 128,
    parameter  int MEM_DEPTH  = 1024,
    parameter  int SETTLE_CYC = 4,
    localparam int SEL_W      = $clog2(SB_N),
    localparam int ADDR_W     = $clog2(MEM_DEPTH)
) (
    input  logic              axi_clk,
    input  logic              axi_reset_n,
    input  logic              init_req,
    input  logic              abort,
    input  logic [SB_N-1:0]   sb_enable_mask,
    input  logic              wr_ready,
    output logic              wr_valid,
    output logic [SEL_W-1:0]  wr_sel,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [SB_N-1:0]   force_freeze,
    output logic [SB_N-1:0]   sb_ptr_reset,
    output logic              busy,
    output logic              done
);

    localparam int                CNT_W     = $clog2(SETTLE_CYC) + 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SETTLE_CYC - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(MEM_DEPTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETTLE = 3'd1,
        CLEAR  = 3'd2,
        PRST   = 3'd3,
        FINISH = 3'd4
    } state_t;

    // Lowest set bit of a mask; callers only use it when the mask is nonzero.
    function automatic logic [SEL_W-1:0] lowest_idx(input logic [SB_N-1:0] m);
        lowest_idx = '0;
        for (int i = SB_N - 1; i >= 0; i--) begin
            if (m[i]) lowest_idx = SEL_W'(i);
        end
    endfunction

    function automatic logic [SB_N-1:0] onehot(input logic [SEL_W-1:0] idx);
        onehot = {{(SB_N-1){1'b0}}, 1'b1} << idx;
    endfunction

    state_t             state_q, state_d;
    logic               req_q, req_d;
    logic [SB_N-1:0]    pend_q, pend_d;
    logic [SB_N-1:0]    orig_q, orig_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               wr_valid_q, wr_valid_d;
    logic [SEL_W-1:0]   wr_sel_q, wr_sel_d;
    logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
    logic [SB_N-1:0]    force_freeze_q, force_freeze_d;
    logic [SB_N-1:0]    sb_ptr_reset_q, sb_ptr_reset_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               start;
    logic [SB_N-1:0]    pend_left;

    // req_q resets high so a level already asserted at reset release is not seen as an edge.
    assign start     = init_req & ~req_q;
    assign pend_left = pend_q & ~onehot(sel_q);

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d = state_q;
        req_d   = init_req;
        pend_d  = pend_q;
        orig_d  = orig_q;
        sel_d   = sel_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    pend_d  = sb_enable_mask;
                    orig_d  = sb_enable_mask;
                    cnt_d   = '0;
                    state_d = (|sb_enable_mask) ? SETTLE : FINISH;
                end
            end
            SETTLE: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    sel_d   = lowest_idx(pend_q);
                    addr_d  = '0;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                if (wr_valid_q && wr_ready) begin
                    if (addr_q == ADDR_LAST) state_d = PRST;
                    else                     addr_d  = addr_q + 1'b1;
                end
            end
            PRST: begin
                pend_d = pend_left;
                if (|pend_left) begin
                    sel_d   = lowest_idx(pend_left);
                    addr_d  = '0;
                    state_d = CLEAR;
                end else begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                pend_d  = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Abort wins over anything decided above, including a same-cycle accept.
        if (abort && (state_q != IDLE)) begin
            state_d = IDLE;
            pend_d  = '0;
        end

        busy_d         = (state_d != IDLE);
        done_d         = (state_d == FINISH);
        wr_valid_d     = (state_d == CLEAR);
        wr_sel_d       = (state_d == CLEAR) ? sel_d  : '0;
        wr_addr_d      = (state_d == CLEAR) ? addr_d : '0;
        force_freeze_d = busy_d ? orig_d : '0;
        sb_ptr_reset_d = (state_d == PRST) ? onehot(sel_d) : '0;
    end

    // Single state/output register bank; async reset clears all outputs immediately.
    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            state_q        <= IDLE;
            req_q          <= 1'b1;
            pend_q         <= '0;
            orig_q         <= '0;
            sel_q          <= '0;
            addr_q         <= '0;
            cnt_q          <= '0;
            wr_valid_q     <= 1'b0;
            wr_sel_q       <= '0;
            wr_addr_q      <= '0;
            force_freeze_q <= '0;
            sb_ptr_reset_q <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            req_q          <= req_d;
            pend_q         <= pend_d;
            orig_q         <= orig_d;
            sel_q          <= sel_d;
            addr_q         <= addr_d;
            cnt_q          <= cnt_d;
            wr_valid_q     <= wr_valid_d;
            wr_sel_q       <= wr_sel_d;
            wr_addr_q      <= wr_addr_d;
            force_freeze_q <= force_freeze_d;
            sb_ptr_reset_q <= sb_ptr_reset_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

    assign wr_valid     = wr_valid_q;
    assign wr_sel       = wr_sel_q;
    assign wr_addr      = wr_addr_q;
    assign force_freeze = force_freeze_q;
    assign sb_ptr_reset = sb_ptr_reset_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_fm_sb_init_seq.sv
// Testbench for fm_sb_init_seq with a small configuration (4 buffers x 8 words, settle 2).
// Inputs are driven 1 time unit after the rising edge; outputs are sampled at the same point.
// Reference: expected write queue per sequence plus closed-form busy length.
module tb_fm_sb_init_seq;

    localparam int SB_N       = 4;
    localparam int MEM_DEPTH  = 8;
    localparam int SETTLE_CYC = 2;

    logic            axi_clk = 1'b0;
    logic            axi_reset_n = 1'b0;
    logic            init_req = 1'b0;
    logic            abort = 1'b0;
    logic [SB_N-1:0] sb_enable_mask = '0;
    logic            wr_ready = 1'b0;
    logic            wr_valid;
    logic [1:0]      wr_sel;
    logic [2:0]      wr_addr;
    logic [SB_N-1:0] force_freeze;
    logic [SB_N-1:0] sb_ptr_reset;
    logic            busy;
    logic            done;

    int tests = 0;
    int fails = 0;

    fm_sb_init_seq #(
        .SB_N      (SB_N),
        .MEM_DEPTH (MEM_DEPTH),
        .SETTLE_CYC(SETTLE_CYC)
    ) dut (
        .axi_clk       (axi_clk),
        .axi_reset_n   (axi_reset_n),
        .init_req      (init_req),
        .abort         (abort),
        .sb_enable_mask(sb_enable_mask),
        .wr_ready      (wr_ready),
        .wr_valid      (wr_valid),
        .wr_sel        (wr_sel),
        .wr_addr       (wr_addr),
        .force_freeze  (force_freeze),
        .sb_ptr_reset  (sb_ptr_reset),
        .busy          (busy),
        .done          (done)
    );

    always #5 axi_clk = ~axi_clk;

    task automatic step();
        @(posedge axi_clk);
        #1;
    endtask

    task automatic test_reset();
        int busy_seen;
        axi_reset_n = 1'b0;
        init_req    = 1'b1;
        sb_enable_mask = 4'b1111;
        #23;
        tests++;
        if ({wr_valid, wr_sel, wr_addr, force_freeze, sb_ptr_reset, busy, done} !== '0) begin
            fails++;
            $display("FAIL reset_values: got %b required 0",
                     {wr_valid, wr_sel, wr_addr, force_freeze, sb_ptr_reset, busy, done});
        end
        @(negedge axi_clk);
        axi_reset_n = 1'b1;
        busy_seen = 0;
        repeat (8) begin
            step();
            if (busy || done || wr_valid) busy_seen++;
        end
        tests++;
        if (busy_seen != 0) begin
            fails++;
            $display("FAIL req_high_at_release: busy/write cycles %0d required 0", busy_seen);
        end
    endtask

    // One complete sequence checked against a queue of expected writes.
    task automatic run_seq(input logic [SB_N-1:0] mask, input bit rand_ready,
                           input bit glitch_req, input string name);
        int exp_q[$];
        int busy_cyc, done_cnt, first_wr, k, exp_busy, got;
        bit done_last, finished, prev_stall;
        logic [1:0] prev_sel;
        logic [2:0] prev_addr;
        logic [SB_N-1:0] exp_prst;

        k = 0;
        for (int b = 0; b < SB_N; b++) begin
            if (mask[b]) begin
                k++;
                for (int a = 0; a < MEM_DEPTH; a++) exp_q.push_back(b * MEM_DEPTH + a);
            end
        end
        exp_busy = (mask == '0) ? 1 : SETTLE_CYC + k * (MEM_DEPTH + 1) + 1;

        abort    = 1'b0;
        init_req = 1'b0;
        wr_ready = 1'b1;
        step();
        sb_enable_mask = mask;
        init_req = 1'b1;
        step();
        sb_enable_mask = 4'($urandom);

        busy_cyc = 0; done_cnt = 0; first_wr = -1; done_last = 0; finished = 0;
        prev_stall = 0; prev_sel = '0; prev_addr = '0; exp_prst = '0;
        for (int c = 0; c < 2000; c++) begin
            if (!busy) begin
                finished = 1;
                break;
            end
            busy_cyc++;
            tests++;
            if (force_freeze !== mask) begin
                fails++;
                $display("FAIL %s force_freeze: got %b required %b", name, force_freeze, mask);
            end
            tests++;
            if (sb_ptr_reset !== exp_prst) begin
                fails++;
                $display("FAIL %s sb_ptr_reset cyc %0d: got %b required %b", name, busy_cyc,
                         sb_ptr_reset, exp_prst);
            end
            if (done) done_cnt++;
            done_last = done;
            if (wr_valid) begin
                if (first_wr < 0) first_wr = busy_cyc;
                if (prev_stall) begin
                    tests++;
                    if ({wr_sel, wr_addr} !== {prev_sel, prev_addr}) begin
                        fails++;
                        $display("FAIL %s stall_stable: got %0d/%0d required %0d/%0d", name,
                                 wr_sel, wr_addr, prev_sel, prev_addr);
                    end
                end
            end
            wr_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (glitch_req && busy_cyc == 5) init_req = 1'b0;
            if (glitch_req && busy_cyc == 6) init_req = 1'b1;
            exp_prst = '0;
            if (wr_valid && wr_ready) begin
                got = int'(wr_sel) * MEM_DEPTH + int'(wr_addr);
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL %s write_order: got %0d/%0d required none", name, wr_sel, wr_addr);
                end else begin
                    if (got != exp_q[0]) begin
                        fails++;
                        $display("FAIL %s write_order: got %0d/%0d required %0d/%0d", name,
                                 wr_sel, wr_addr, exp_q[0] / MEM_DEPTH, exp_q[0] % MEM_DEPTH);
                    end
                    void'(exp_q.pop_front());
                end
                if (int'(wr_addr) == MEM_DEPTH - 1) exp_prst = 4'b0001 << wr_sel;
            end
            prev_stall = wr_valid && !wr_ready;
            prev_sel   = wr_sel;
            prev_addr  = wr_addr;
            step();
        end

        tests++;
        if (!finished) begin
            fails++;
            $display("FAIL %s timeout: busy still %b required 0", name, busy);
        end
        tests++;
        if ({wr_valid, wr_sel, wr_addr, force_freeze, sb_ptr_reset, busy, done} !== '0) begin
            fails++;
            $display("FAIL %s idle_after: got %b required 0", name,
                     {wr_valid, wr_sel, wr_addr, force_freeze, sb_ptr_reset, busy, done});
        end
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL %s writes_left: got %0d required 0", name, exp_q.size());
        end
        tests++;
        if (done_cnt != 1 || !done_last) begin
            fails++;
            $display("FAIL %s done: count %0d last %b required 1 1", name, done_cnt, done_last);
        end
        if (mask != '0) begin
            tests++;
            if (first_wr != SETTLE_CYC + 1) begin
                fails++;
                $display("FAIL %s first_write: busy cycle %0d required %0d", name, first_wr,
                         SETTLE_CYC + 1);
            end
        end
        if (!rand_ready) begin
            tests++;
            if (busy_cyc != exp_busy) begin
                fails++;
                $display("FAIL %s busy_len: got %0d required %0d", name, busy_cyc, exp_busy);
            end
        end
    endtask

    task automatic test_basic();
        run_seq(4'b0101, 1'b0, 1'b0, "basic_0101");
    endtask

    task automatic test_zero_mask();
        run_seq(4'b0000, 1'b0, 1'b0, "zero_mask");
    endtask

    task automatic test_random_ready();
        run_seq(4'b0101, 1'b1, 1'b0, "rand_0101");
        repeat (4) run_seq(4'($urandom_range(1, 15)), 1'b1, 1'b0, "rand_mask");
    endtask

    task automatic test_rearm();
        int busy_seen;
        run_seq(4'b1001, 1'b0, 1'b1, "glitch_while_busy");
        busy_seen = 0;
        repeat (10) begin
            step();
            if (busy) busy_seen++;
        end
        tests++;
        if (busy_seen != 0) begin
            fails++;
            $display("FAIL held_req_restart: busy cycles %0d required 0", busy_seen);
        end
        run_seq(4'b0010, 1'b0, 1'b0, "rearm");
    endtask

    task automatic test_abort();
        bit found;
        int dirty;
        init_req = 1'b0;
        wr_ready = 1'b1;
        step();
        sb_enable_mask = 4'b1111;
        init_req = 1'b1;
        step();
        found = 0;
        for (int c = 0; c < 200; c++) begin
            if (wr_valid && wr_sel == 2'd0 && wr_addr == 3'd3) begin
                abort = 1'b1;
                found = 1;
                step();
                break;
            end
            step();
        end
        abort = 1'b0;
        tests++;
        if (!found) begin
            fails++;
            $display("FAIL abort_reach: write sel0 addr3 seen %b required 1", found);
        end
        tests++;
        if ({wr_valid, wr_sel, wr_addr, force_freeze, sb_ptr_reset, busy, done} !== '0) begin
            fails++;
            $display("FAIL abort_idle: got %b required 0",
                     {wr_valid, wr_sel, wr_addr, force_freeze, sb_ptr_reset, busy, done});
        end
        dirty = 0;
        repeat (20) begin
            step();
            if (done || busy || wr_valid || sb_ptr_reset != '0) dirty++;
        end
        tests++;
        if (dirty != 0) begin
            fails++;
            $display("FAIL abort_quiet: active cycles %0d required 0", dirty);
        end
    endtask

    task automatic test_async_reset();
        bit found;
        int dirty;
        init_req = 1'b0;
        wr_ready = 1'b1;
        step();
        sb_enable_mask = 4'b0110;
        init_req = 1'b1;
        step();
        found = 0;
        for (int c = 0; c < 200; c++) begin
            if (wr_valid && wr_addr == 3'd2) begin
                found = 1;
                break;
            end
            step();
        end
        tests++;
        if (!found) begin
            fails++;
            $display("FAIL arst_reach: mid-clear write seen %b required 1", found);
        end
        #3;
        axi_reset_n = 1'b0;
        #1;
        tests++;
        if ({wr_valid, wr_sel, wr_addr, force_freeze, sb_ptr_reset, busy, done} !== '0) begin
            fails++;
            $display("FAIL arst_immediate: got %b required 0",
                     {wr_valid, wr_sel, wr_addr, force_freeze, sb_ptr_reset, busy, done});
        end
        #20;
        @(negedge axi_clk);
        axi_reset_n = 1'b1;
        dirty = 0;
        repeat (10) begin
            step();
            if (done || busy || wr_valid || sb_ptr_reset != '0) dirty++;
        end
        tests++;
        if (dirty != 0) begin
            fails++;
            $display("FAIL arst_idle_after: active cycles %0d required 0", dirty);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_mask();
        test_random_ready();
        test_rearm();
        test_abort();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fm_sb_init_seq.md
# fm_sb_init_seq

Spy-memory initialization sequencer for the FM spy-buffer block. On a rising edge of the INITIALIZE_SPY_MEMORY control bit, it force-freezes the selected spy buffers and waits a settle interval. It then zero-fills each selected buffer through a single shared write port, lowest index first, and pulses that buffer's pointer reset. It sits beside the spy-buffer control block, and its `force_freeze` is OR'd into the per-buffer freeze at the top level.

## Interface
- `SB_N`, 128: number of mapped spy buffers.
- `MEM_DEPTH`, 1024: words per spy buffer; power of two, ≥2.
- `SETTLE_CYC`, 4: freeze-settle cycles before the first write; ≥1.
- `axi_clk` in 1: clock.
- `axi_reset_n` in 1: reset; asynchronous, active-low.
- `init_req` in 1: level from SPY_CTRL.INITIALIZE_SPY_MEMORY. A rising edge starts a sequence.
- `abort` in 1: synchronous abort.
- `sb_enable_mask` in SB_N: buffers to initialize (1 = include). Sampled only at start.
- `wr_ready` in 1: shared write port accepts this cycle.
- `wr_valid` out 1: write request; the data written is implicitly zero.
- `wr_sel` out $clog2(SB_N): target buffer index.
- `wr_addr` out $clog2(MEM_DEPTH): target word address.
- `force_freeze` out SB_N: latched mask while busy, else 0.
- `sb_ptr_reset` out SB_N: one-cycle pointer-reset pulse for the buffer just cleared.
- `busy` out 1: sequencer not IDLE.
- `done` out 1: one-cycle completion pulse.

## Operation
- State register: IDLE, SETTLE, CLEAR, PRST, FINISH. Outputs are decoded from the state, `pend` (latched mask), `sel`, `addr` and `cnt`.
- Edge detect: `req_q` is `init_req` delayed one cycle; its reset value is 1. `start` = `init_req & ~req_q`. A level still high at reset release does not start a sequence.
- **IDLE**, on `start`:
  - `pend` ← `sb_enable_mask`, `cnt` ← 0.
  - If the mask is nonzero, go to SETTLE; if it is zero, go to FINISH.
- **SETTLE**:
  - `cnt` increments each cycle.
  - When `cnt` == SETTLE_CYC-1: `sel` ← lowest set index of `pend`, `addr` ← 0, go to CLEAR.
- **CLEAR**:
  - `wr_valid`=1; `wr_sel`=`sel`; `wr_addr`=`addr`. These are held stable until accepted.
  - An accept (`wr_valid & wr_ready`) at `addr` == MEM_DEPTH-1 goes to PRST; any other accept increments `addr`.
- **PRST**:
  - `sb_ptr_reset[sel]`=1; `pend[sel]` cleared.
  - If the remaining `pend` is nonzero: `sel` ← next lowest set index, `addr` ← 0, go to CLEAR. Otherwise go to FINISH.
- **FINISH**: `done`=1, then IDLE.
- `busy` = (state ≠ IDLE). `force_freeze` = `pend_orig` (mask at start) while busy.
- `abort`:
  - In any non-IDLE state it forces IDLE next cycle, with no `done` and no further `sb_ptr_reset`.
  - It takes priority over a same-cycle accept; that write may land, but the sequencer ignores it.
- `start` while busy is ignored. A new sequence needs `init_req` low then high after returning to IDLE.
- `sb_enable_mask` changes after start have no effect.

## Timing
- Reset values: state IDLE; `wr_valid`, `wr_sel`, `wr_addr`, `force_freeze`, `sb_ptr_reset`, `busy`, `done` all 0; `req_q`=1.
- Async reset mid-sequence clears outputs immediately; there is no `done`.
- `busy` and `force_freeze` rise on the clock edge that samples `start`.
- The first `wr_valid` comes SETTLE_CYC cycles after `busy` rises.
- With `wr_ready` held at 1:
  - Each buffer costs MEM_DEPTH CLEAR cycles plus 1 PRST cycle.
  - `busy` is high for SETTLE_CYC + k·(MEM_DEPTH+1) + 1 cycles, for k selected buffers.
- `done` is asserted in the last busy cycle. `busy` and `force_freeze` fall on the next edge.
- Zero mask: `busy` and `done` are high together for exactly one cycle, with no writes.
- `wr_ready` low stalls CLEAR indefinitely; no timeout.

## Test plan
- SB_N=4, MEM_DEPTH=8, SETTLE_CYC=2, mask=0101, `wr_ready`=1:
  - `force_freeze`=0101 for 21 cycles.
  - Writes sel0 addr0..7, then `sb_ptr_reset`=0001.
  - Writes sel2 addr0..7, then `sb_ptr_reset`=0100.
  - `done` in cycle 21, then all outputs 0.
- Same config with `wr_ready` toggling pseudo-randomly:
  - `wr_sel`/`wr_addr` stable while `wr_valid` & !`wr_ready`.
  - Exactly 8 accepted writes per buffer, in order; `done` pulses once.
- mask=0000 with a rising `init_req`: `busy`=`done`=1 for one cycle, no `wr_valid`, no `sb_ptr_reset`.
- mask=1111, `abort` at the cycle sel=0 addr=3 is accepted:
  - IDLE next cycle; all outputs 0.
  - No `done`; no `sb_ptr_reset` pulse.
- Start/re-arm behaviour:
  - `init_req` held high through completion: no restart.
  - A second rising edge while busy is ignored.
  - Low→high after IDLE restarts a sequence.
  - `init_req` high across `axi_reset_n` release does not start one.
- Assert `axi_reset_n`=0 asynchronously mid-CLEAR (between edges): all outputs 0 before the next edge. After release, state is IDLE.
